// File: rtl/mario_frame_ctrl.sv
// Frame sequencer for the Mario sprite: stage draw, then per frame tick erase -> move -> draw.
// Optional jump physics are compiled in when MARIO_JUMP_EN is defined.
module mario_frame_ctrl #(
  parameter int FRAME_DIV = 833333,
  parameter int SCREEN_W  = 160,
  parameter int SPRITE_W  = 12,
  parameter int GROUND_Y  = 104,
  parameter int START_X   = 8,
  parameter int STEP_X    = 1,
  parameter int JUMP_V    = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       done,
  output logic       drStage1,
  output logic       erM,
  output logic       drM,
  output logic [7:0] px,
  output logic [7:0] py,
  output logic       busy
);

  localparam int                CW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0]     CNT_MAX = CW'(FRAME_DIV - 1);
  localparam logic signed [8:0] STEP9   = 9'(STEP_X);
  localparam logic signed [8:0] MAX_X9  = 9'(SCREEN_W - SPRITE_W);
  localparam logic [7:0]        GROUND8 = 8'(GROUND_Y);
  localparam logic [7:0]        START8  = 8'(START_X);

  // Two gap states so the single idle cycle after a request knows where to go next.
  typedef enum logic [2:0] {
    S_BKG, S_GAP_BKG, S_DRAW, S_IDLE, S_ERASE, S_GAP_ERASE, S_UPDATE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            tick, pending;
  logic [1:0]      left_q, right_q;
  logic            left_s, right_s;
  logic signed [8:0] x_sum;
  logic [7:0]      px_next, py_next;

  // NOTE: synchroniser flops carry no reset; they only retime the pins and settle in two cycles.
  always_ff @(posedge clk) begin
    left_q  <= {left_q[0], key_left};
    right_q <= {right_q[0], key_right};
  end
  assign left_s  = left_q[1];
  assign right_s = right_q[1];

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      // A tick wins over the clear so a tick on the accept cycle is not lost.
      if (tick)                 pending <= 1'b1;
      else if (state == S_IDLE) pending <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_BKG:       if (done && drStage1) state_n = S_GAP_BKG;
      S_GAP_BKG:   state_n = S_DRAW;
      S_DRAW:      if (done && drM) state_n = S_IDLE;
      S_IDLE:      if (pending) state_n = S_ERASE;
      S_ERASE:     if (done && erM) state_n = S_GAP_ERASE;
      S_GAP_ERASE: state_n = S_UPDATE;
      S_UPDATE:    state_n = S_DRAW;
      default:     state_n = S_BKG;
    endcase
  end

  // Requests are registered from the next state, so done is only honoured once
  // the request is visible; a stray done right after reset is ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_BKG;
      drStage1 <= 1'b0;
      erM      <= 1'b0;
      drM      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      drStage1 <= (state_n == S_BKG);
      erM      <= (state_n == S_ERASE);
      drM      <= (state_n == S_DRAW);
      busy     <= (state_n == S_BKG) || (state_n == S_ERASE) || (state_n == S_DRAW);
    end
  end

  always_comb begin
    x_sum = $signed({1'b0, px});
    if (left_s && !right_s)      x_sum = x_sum - STEP9;
    else if (right_s && !left_s) x_sum = x_sum + STEP9;
    if (x_sum[8])               px_next = '0;
    else if (x_sum > MAX_X9)    px_next = MAX_X9[7:0];
    else                        px_next = x_sum[7:0];
  end

`ifdef MARIO_JUMP_EN
  localparam logic signed [5:0] LAUNCH_V = 6'(-JUMP_V);
  localparam logic signed [9:0] GROUND10 = 10'(GROUND_Y);

  logic [1:0]        jump_q;
  logic              jump_s;
  logic signed [5:0] vy, vy_next;
  logic signed [9:0] y_sum;

  always_ff @(posedge clk) jump_q <= {jump_q[0], key_jump};
  assign jump_s = jump_q[1];

  always_comb begin
    py_next = py;
    vy_next = vy;
    y_sum   = $signed({2'b00, py}) + $signed({{4{vy[5]}}, vy});
    if (py == GROUND8 && vy == '0) begin
      if (jump_s) vy_next = LAUNCH_V;
    end else if (y_sum[9]) begin
      py_next = '0;
      vy_next = '0;
    end else if (y_sum >= GROUND10) begin
      py_next = GROUND8;
      vy_next = '0;
    end else begin
      py_next = y_sum[7:0];
      vy_next = vy + 6'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)               vy <= '0;
    else if (state == S_UPDATE) vy <= vy_next;
  end
`else
  logic unused_jump;
  assign unused_jump = key_jump;
  assign py_next     = py;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      px <= START8;
      py <= GROUND8;
    end else if (state == S_UPDATE) begin
      px <= px_next;
      py <= py_next;
    end
  end

endmodule
